rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports alu_valid (in, 1), alu_rd (in, 5), alu_data (in, 32), alu_ready (out, 1): ALU writeback request channel.
REQ-004 SHALL have ports lsu_valid (in, 1), lsu_rd (in, 5), lsu_data (in, 32), lsu_type (in, 3), lsu_ready (out, 1): load-unit writeback channel; lsu_type uses the register-file write-enable code (1 LW, 2 LB, 3 LH, 4 LBU, 5 LHU).
REQ-005 SHALL have ports iss_valid (in, 1), iss_rd (in, 5): issue marks a destination register pending.
REQ-006 SHALL have ports rs1 (in, 5), rs2 (in, 5), stall (out, 1): hazard query.
REQ-007 SHALL have ports A3 (out, 5), WD3 (out, 32), WE3 (out, 3): register-file write port, driven from registers.
REQ-008 SHALL have port busy (out, 32): pending-write scoreboard, bit n = register n.

Function
REQ-009 SHALL complete a channel transfer on a cycle where valid and ready are both high; ready is combinational from valid and the arbitration state.
REQ-010 SHALL grant at most one channel per cycle; the losing channel's ready SHALL be low and its inputs are held by the requester.
REQ-011 SHALL register the granted transfer so that A3/WD3/WE3 present it on the cycle after the handshake (latency 1); WE3 SHALL be 0 in every cycle with no transfer in the previous cycle.
REQ-012 SHALL drive WE3=1 for an ALU transfer and WE3=lsu_type for an LSU transfer; lsu_type 0, 6 or 7 SHALL produce WE3=0 (handshake completes, no write).
REQ-013 SHALL drive WE3=0 for any transfer with rd=0 (accepted, discarded).
REQ-014 SHALL set busy[iss_rd] on the clock edge where iss_valid=1 and iss_rd!=0.
REQ-015 SHALL clear busy[A3] on the clock edge ending a cycle where the registered write (A3, WE3 from REQ-011) is valid, i.e. when the register file commits the write.
REQ-016 SHALL give set priority over clear when REQ-014 and REQ-015 target the same register in the same edge.
REQ-017 SHALL hold busy[0]=0 at all times.
REQ-018 SHALL drive stall=1 combinationally when busy[rs1] or busy[rs2] is 1, including the cycle the write is on WE3 (register-file read still returns the old value).
REQ-019 SHALL never stall on rs1=0 or rs2=0.

Reset
REQ-020 SHALL, while rst=0, force busy=0, A3=0, WD3=0, WE3=0, alu_ready=0, lsu_ready=0, arbitration pointer = ALU-next-favoured-LSU (LSU wins first contested grant).
REQ-021 SHALL drop a transfer registered in the cycle rst asserts; no write appears after rst deasserts.
REQ-022 SHALL assert no ready on the first clk edge after rst deasserts only if no valid is high; otherwise grant per REQ-023/024 immediately.

Configuration
REQ-023 SHALL, with RF_WB_RR_EN defined, arbitrate contested cycles round-robin: the channel granted last loses the next contested cycle; uncontested grants also update the pointer.
REQ-024 SHALL, with RF_WB_RR_EN undefined, use fixed priority LSU over ALU and keep no pointer state.

Verification
REQ-025 Bench SHALL check: iss x5, then ALU valid rd=5 data 0x1234 -> alu_ready=1 same cycle; next cycle A3=5, WD3=0x1234, WE3=1; busy[5]=1 through that cycle, 0 after the edge.
REQ-026 Bench SHALL check: ALU and LSU valid together for 4 cycles with RR_EN -> grants LSU, ALU, LSU, ALU; without RR_EN -> LSU every cycle, alu_ready=0.
REQ-027 Bench SHALL check: LSU rd=7 type 2 data 0x80 -> WE3=2, A3=7; type 6 -> WE3=0 and busy[7] still cleared.
REQ-028 Bench SHALL check: iss_rd=9 on the same edge busy[9] is cleared by a commit -> busy[9]=1 after the edge.
REQ-029 Bench SHALL check: rs1=0, rs2=3 with busy[3]=1 -> stall=1; rs1=rs2=0 with iss_rd=0 -> busy[0]=0, stall=0.
REQ-030 Bench SHALL check: rst pulse low mid-transfer with busy=0xFFFFFFFE -> busy=0, WE3=0 immediately and on the edge after release.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: ALU/LSU channels share one registered write port, with a pending-write scoreboard.
// Define RF_WB_RR_EN for round-robin arbitration; otherwise the LSU has fixed priority.
module rf_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic [2:0]  lsu_type,
  output logic        lsu_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        stall,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic [2:0]  WE3,
  output logic [31:0] busy
);

  logic        w_grant_lsu;
  logic        w_grant_alu;
  logic        w_xfer;
  logic [4:0]  w_rd;
  logic [31:0] w_data;
  logic [2:0]  w_we;
  logic [31:0] w_busy_nxt;

  logic        r_wb_vld;
  logic [4:0]  r_a3;
  logic [31:0] r_wd3;
  logic [2:0]  r_we3;
  logic [31:0] r_busy;

`ifdef RF_WB_RR_EN
  // Set after an LSU grant: the ALU wins the next contested cycle.
  logic r_pref_alu;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pref_alu <= 1'b0;
    end else if (w_xfer) begin
      r_pref_alu <= w_grant_lsu;
    end
  end

  assign w_grant_lsu = lsu_valid & (~alu_valid | ~r_pref_alu);
`else
  assign w_grant_lsu = lsu_valid;
`endif

  assign w_grant_alu = alu_valid & ~w_grant_lsu;
  assign alu_ready   = rst & w_grant_alu;
  assign lsu_ready   = rst & w_grant_lsu;
  assign w_xfer      = alu_ready | lsu_ready;

  always_comb begin
    w_rd   = alu_rd;
    w_data = alu_data;
    w_we   = 3'd1;
    if (lsu_ready) begin
      w_rd   = lsu_rd;
      w_data = lsu_data;
      w_we   = ((lsu_type >= 3'd1) && (lsu_type <= 3'd5)) ? lsu_type : 3'd0;
    end
    if (w_rd == 5'd0) begin
      w_we = 3'd0;
    end
  end

  // A committed transfer clears its register even if the type code suppressed the write.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wb_vld) begin
      w_busy_nxt[r_a3] = 1'b0;
    end
    if (iss_valid && (iss_rd != 5'd0)) begin
      w_busy_nxt[iss_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_vld <= 1'b0;
      r_a3     <= 5'd0;
      r_wd3    <= 32'd0;
      r_we3    <= 3'd0;
      r_busy   <= 32'd0;
    end else begin
      r_wb_vld <= w_xfer;
      r_we3    <= w_xfer ? w_we : 3'd0;
      if (w_xfer) begin
        r_a3  <= w_rd;
        r_wd3 <= w_data;
      end
      r_busy <= w_busy_nxt;
    end
  end

  assign A3    = r_a3;
  assign WD3   = r_wd3;
  assign WE3   = r_we3;
  assign busy  = r_busy;
  assign stall = ((rs1 != 5'd0) & r_busy[rs1]) | ((rs2 != 5'd0) & r_busy[rs2]);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter; expectations follow RF_WB_RR_EN when it is defined.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, iss_valid;
  logic [4:0]  alu_rd, lsu_rd, iss_rd, rs1, rs2;
  logic [31:0] alu_data, lsu_data;
  logic [2:0]  lsu_type;
  logic        alu_ready, lsu_ready, stall;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [2:0]  WE3;
  logic [31:0] busy;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef RF_WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_type(lsu_type),
    .lsu_ready(lsu_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rs1(rs1), .rs2(rs2), .stall(stall),
    .A3(A3), .WD3(WD3), .WE3(WE3), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h0;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h0; lsu_type = 3'd1;
    iss_valid = 1'b0; iss_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;

    // reset state
    tick(); tick();
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_we3", {29'd0, WE3}, 32'd0);
    chk("rst_a3", {27'd0, A3}, 32'd0);
    chk("rst_wd3", WD3, 32'd0);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    #1 rst = 1'b1;
    tick();
    chk("post_rst_we3", {29'd0, WE3}, 32'd0);

    // issue x5, ALU writeback of x5
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    iss_valid = 1'b0;
    chk("iss5_busy", busy, 32'h20);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234; rs1 = 5'd5;
    #1;
    chk("alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("stall_rs1_5", {31'd0, stall}, 32'd1);
    tick();
    alu_valid = 1'b0;
    chk("alu_a3", {27'd0, A3}, 32'd5);
    chk("alu_wd3", WD3, 32'h1234);
    chk("alu_we3", {29'd0, WE3}, 32'd1);
    chk("alu_busy_wb", {31'd0, busy[5]}, 32'd1);
    chk("stall_on_wb", {31'd0, stall}, 32'd1);
    tick();
    chk("alu_busy_clr", {31'd0, busy[5]}, 32'd0);
    chk("alu_we3_idle", {29'd0, WE3}, 32'd0);
    chk("stall_clr", {31'd0, stall}, 32'd0);
    rs1 = 5'd0;

    // contested channels for four cycles
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hA11;
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hB10; lsu_type = 3'd3;
    for (int i = 0; i < 4; i++) begin
      logic exp_lsu;
      exp_lsu = RR ? (i % 2 == 0) : 1'b1;
      #1;
      chk($sformatf("arb%0d_lsu_ready", i), {31'd0, lsu_ready}, {31'd0, exp_lsu});
      chk($sformatf("arb%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, ~exp_lsu});
      tick();
      chk($sformatf("arb%0d_a3", i), {27'd0, A3}, exp_lsu ? 32'd10 : 32'd11);
      chk($sformatf("arb%0d_we3", i), {29'd0, WE3}, exp_lsu ? 32'd3 : 32'd1);
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    tick(); tick();

    // LSU byte load, then an invalid type that still clears busy
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    iss_valid = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h80; lsu_type = 3'd2;
    tick();
    lsu_valid = 1'b0;
    chk("lb_we3", {29'd0, WE3}, 32'd2);
    chk("lb_a3", {27'd0, A3}, 32'd7);
    chk("lb_wd3", WD3, 32'h80);
    tick();
    chk("lb_busy_clr", {31'd0, busy[7]}, 32'd0);
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    iss_valid = 1'b0;
    lsu_valid = 1'b1; lsu_type = 3'd6;
    tick();
    lsu_valid = 1'b0;
    chk("t6_we3", {29'd0, WE3}, 32'd0);
    chk("t6_a3", {27'd0, A3}, 32'd7);
    chk("t6_busy_wb", {31'd0, busy[7]}, 32'd1);
    tick();
    chk("t6_busy_clr", {31'd0, busy[7]}, 32'd0);

    // ALU write to rd=0 is discarded
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFF;
    tick();
    alu_valid = 1'b0;
    chk("rd0_we3", {29'd0, WE3}, 32'd0);
    tick();

    // set wins over clear on x9
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9;
    tick();
    alu_valid = 1'b0;
    chk("x9_we3", {29'd0, WE3}, 32'd1);
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0;
    chk("x9_set_wins", {31'd0, busy[9]}, 32'd1);

    // stall queries with x0
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick();
    iss_valid = 1'b0;
    rs1 = 5'd0; rs2 = 5'd3;
    #1;
    chk("stall_rs2_3", {31'd0, stall}, 32'd1);
    rs1 = 5'd0; rs2 = 5'd0; iss_valid = 1'b1; iss_rd = 5'd0;
    tick();
    iss_valid = 1'b0;
    chk("busy0", {31'd0, busy[0]}, 32'd0);
    chk("stall_x0", {31'd0, stall}, 32'd0);
    chk("busy_x3_x9", busy, 32'h208);

    // fill scoreboard, then reset during a write
    for (int i = 1; i < 32; i++) begin
      iss_valid = 1'b1; iss_rd = i[4:0];
      tick();
    end
    iss_valid = 1'b0;
    chk("busy_full", busy, 32'hFFFF_FFFE);
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hDEAD;
    tick();
    alu_valid = 1'b0;
    chk("mid_we3", {29'd0, WE3}, 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_busy", busy, 32'd0);
    chk("arst_we3", {29'd0, WE3}, 32'd0);
    chk("arst_a3", {27'd0, A3}, 32'd0);
    #2 rst = 1'b1;
    tick();
    chk("rel_busy", busy, 32'd0);
    chk("rel_we3", {29'd0, WE3}, 32'd0);

    // valid held through reset is granted immediately on release
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h55;
    #1;
    chk("rstv_alu_ready", {31'd0, alu_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("relv_alu_ready", {31'd0, alu_ready}, 32'd1);
    tick();
    alu_valid = 1'b0;
    chk("relv_we3", {29'd0, WE3}, 32'd1);
    chk("relv_a3", {27'd0, A3}, 32'd6);
    chk("relv_wd3", WD3, 32'h55);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
